// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//   Bundles the two writeback request ports, the clear control, the
//   register-file write port and the register-file read snoop/return paths
//   of rf_write_arbiter.
//   slave  : the arbiter side
//   master : the control/datapath + register-file side
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int NREG = 32,
    parameter int DW   = 32
);
    localparam int AW = $clog2(NREG);

    // Port A: ALU writeback
    logic          A_VLD;
    logic [AW-1:0] A_WA;
    logic [DW-1:0] A_WD;
    logic          A_RDY;

    // Port B: memory-load writeback
    logic          B_VLD;
    logic [AW-1:0] B_WA;
    logic [DW-1:0] B_WD;
    logic          B_RDY;

    // Clear control
    logic          CLR;
    logic          BUSY;

    // Register-file write port
    logic          RFWE;
    logic [AW-1:0] RFWA;
    logic [DW-1:0] RFWD;

    // Register-file read paths
    logic [AW-1:0] RFRA1;
    logic [AW-1:0] RFRA2;
    logic [DW-1:0] RFRD1_I;
    logic [DW-1:0] RFRD2_I;
    logic [DW-1:0] RFRD1_O;
    logic [DW-1:0] RFRD2_O;

    modport slave (
        input  A_VLD, A_WA, A_WD,
        output A_RDY,
        input  B_VLD, B_WA, B_WD,
        output B_RDY,
        input  CLR,
        output BUSY,
        output RFWE, RFWA, RFWD,
        input  RFRA1, RFRA2, RFRD1_I, RFRD2_I,
        output RFRD1_O, RFRD2_O
    );

    modport master (
        output A_VLD, A_WA, A_WD,
        input  A_RDY,
        output B_VLD, B_WA, B_WD,
        input  B_RDY,
        output CLR,
        input  BUSY,
        input  RFWE, RFWA, RFWD,
        output RFRA1, RFRA2, RFRD1_I, RFRD2_I,
        input  RFRD1_O, RFRD2_O
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the single register-file write port between port A (ALU
//   writeback) and port B (memory-load writeback) with round-robin
//   arbitration on contention, and runs a clear sequence that writes zero
//   to registers 1..NREG-1 without needing a reset.
//
//   Write-port outputs (RFWE/RFWA/RFWD) and BUSY are registered; RDY is
//   combinational. Register 0 is the hardwired zero: a request to it is
//   accepted but never raises RFWE.
//
//   Optional feature macro: RF_WRITE_BYPASS_EN
//     defined   : the register file is read-first, so read data for an
//                 address currently being written is forwarded from RFWD.
//     undefined : read data passes straight through.
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    rf_write_arbiter_if.slave  bus
);
    localparam int            AW        = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;       // next register to clear
    logic          rr_b_q, rr_b_d;     // 0: A wins next contention, 1: B wins
    logic          busy_q, busy_d;
    logic          rfwe_q, rfwe_d;
    logic [AW-1:0] rfwa_q, rfwa_d;
    logic [DW-1:0] rfwd_q, rfwd_d;
    logic [1:0]    grants_s;           // {grant A, grant B}
    logic          grant_a_s;
    logic          grant_b_s;

    // Round-robin grant for two requesters; returns {grant_a, grant_b}.
    // A lone requester always wins, contention is settled by the pointer.
    function automatic logic [1:0] arb_grant(
        input logic a_vld,
        input logic b_vld,
        input logic rr_b
    );
        logic [1:0] g;
        if (a_vld && b_vld) begin
            g = rr_b ? 2'b01 : 2'b10;
        end else begin
            g = {a_vld, b_vld};
        end
        return g;
    endfunction

    // State register and registered outputs; RST aborts everything at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO_ADDR;
            rr_b_q  <= 1'b0;
            busy_q  <= 1'b0;
            rfwe_q  <= 1'b0;
            rfwa_q  <= ZERO_ADDR;
            rfwd_q  <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_b_q  <= rr_b_d;
            busy_q  <= busy_d;
            rfwe_q  <= rfwe_d;
            rfwa_q  <= rfwa_d;
            rfwd_q  <= rfwd_d;
        end
    end

    // Next-state logic: CLR starts a clear, which ends once the last register is written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CLR) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: grants and next values of the write port, counter and pointer.
    always_comb begin
        grants_s  = 2'b00;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        cnt_d     = cnt_q;
        rr_b_d    = rr_b_q;
        rfwe_d    = 1'b0;
        rfwa_d    = rfwa_q;
        rfwd_d    = rfwd_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CLR) begin
                    // CLR wins over any pending request; they wait until after the clear.
                    cnt_d = ONE_ADDR;
                end else begin
                    grants_s  = arb_grant(bus.A_VLD, bus.B_VLD, rr_b_q);
                    grant_a_s = grants_s[1];
                    grant_b_s = grants_s[0];
                    if (grant_a_s) begin
                        rfwe_d = (bus.A_WA != ZERO_ADDR);
                        rfwa_d = bus.A_WA;
                        rfwd_d = bus.A_WD;
                    end else if (grant_b_s) begin
                        rfwe_d = (bus.B_WA != ZERO_ADDR);
                        rfwa_d = bus.B_WA;
                        rfwd_d = bus.B_WD;
                    end else begin
                        rfwe_d = 1'b0;
                    end
                    // Pointer only moves when it actually decided a contention.
                    if (bus.A_VLD && bus.B_VLD) begin
                        rr_b_d = ~rr_b_q;
                    end else begin
                        rr_b_d = rr_b_q;
                    end
                end
            end
            ST_CLEAR: begin
                rfwe_d = 1'b1;
                rfwa_d = cnt_q;
                rfwd_d = {DW{1'b0}};
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = ZERO_ADDR;
                end else begin
                    cnt_d = cnt_q + ONE_ADDR;
                end
            end
            default: begin
                cnt_d = ZERO_ADDR;
            end
        endcase
    end

    // BUSY tracks the registered state, so it rises on the edge sampling CLR
    // and falls on the edge that registers the final clear write.
    assign busy_d = (state_d == ST_CLEAR);

    assign bus.A_RDY = grant_a_s;
    assign bus.B_RDY = grant_b_s;
    assign bus.BUSY  = busy_q;
    assign bus.RFWE  = rfwe_q;
    assign bus.RFWA  = rfwa_q;
    assign bus.RFWD  = rfwd_q;

`ifdef RF_WRITE_BYPASS_EN
    // Forward the in-flight write to readers of the same non-zero register.
    always_comb begin
        if (rfwe_q && (rfwa_q == bus.RFRA1) && (bus.RFRA1 != ZERO_ADDR)) begin
            bus.RFRD1_O = rfwd_q;
        end else begin
            bus.RFRD1_O = bus.RFRD1_I;
        end
        if (rfwe_q && (rfwa_q == bus.RFRA2) && (bus.RFRA2 != ZERO_ADDR)) begin
            bus.RFRD2_O = rfwd_q;
        end else begin
            bus.RFRD2_O = bus.RFRD2_I;
        end
    end
`else
    // Read data passes straight through; the snooped addresses are not needed.
    logic unused_ra_s;
    assign unused_ra_s  = ^{bus.RFRA1, bus.RFRA2};
    assign bus.RFRD1_O  = bus.RFRD1_I;
    assign bus.RFRD2_O  = bus.RFRD2_I;
`endif

endmodule
